// File: rtl/ram_cmd_master.sv
// rtl/ram_cmd_master.sv - turns one host byte request into the RAM command-word sequence
// Reads wait for tx_valid/dout, bounded by RD_TIMEOUT cycles.
module ram_cmd_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] din,
  output logic                 rx_valid,
  input  logic [7:0]           dout,
  input  logic                 tx_valid
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_DATA, R_ADDR, R_CMD, WAIT, RESP
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 cnt_last;

  assign accept    = req_valid && (state == IDLE);
  assign cnt_last  = (cnt == CNT_LAST);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din       = '0;
    rx_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_write ? W_ADDR : R_ADDR;
      end
      W_ADDR: begin
        rx_valid  = 1'b1;
        din       = {2'b00, addr_q};
        state_nxt = W_DATA;
      end
      W_DATA: begin
        rx_valid  = 1'b1;
        din       = {2'b01, ADDR_SIZE'(wdata_q)};
        state_nxt = RESP;
      end
      R_ADDR: begin
        rx_valid  = 1'b1;
        din       = {2'b10, addr_q};
        state_nxt = R_CMD;
      end
      R_CMD: begin
        rx_valid  = 1'b1;
        din       = {2'b11, {ADDR_SIZE{1'b0}}};
        state_nxt = WAIT;
      end
      WAIT: begin
        // tx_valid on the last counted edge still counts as success
        if (tx_valid || cnt_last) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        R_CMD: cnt <= '0;
        WAIT: begin
          if (tx_valid) begin
            rsp_rdata <= dout;
            rsp_err   <= 1'b0;
          end else if (cnt_last) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_cmd_master.md
# ram_cmd_master

Command initiator for the single-port RAM in the SPI project. It turns one host request (write or read of one byte) into the RAM's 10-bit command-word sequence on `din`/`rx_valid`. For reads it waits for the RAM's `tx_valid`/`dout` and returns the byte. It sits where the SPI slave's parallel side sits and drives the RAM directly; it is also used as a stand-alone RAM stimulus engine.

## Interface
Parameters:
- `ADDR_SIZE`, 8: address width; command word payload width.
- `RD_TIMEOUT`, 15: maximum WAIT-state cycles for `tx_valid` (≥1).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  high iff state is IDLE; accept on `req_valid && req_ready` at an edge.
- `req_write`  in  1  1 = write, 0 = read; sampled at accept.
- `req_addr`  in  ADDR_SIZE  byte address; sampled at accept.
- `req_wdata`  in  8  write byte; sampled at accept.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  8  read byte; 8'h00 for writes and timeouts.
- `rsp_err`  out  1  read timeout flag; qualified by `rsp_valid`.
- `din`  out  ADDR_SIZE+2  RAM command word {op[1:0], payload}; 0 when `rx_valid`=0.
- `rx_valid`  out  1  command word valid to RAM.
- `dout`  in  8  RAM read data.
- `tx_valid`  in  1  RAM read data valid.

## Operation
- Opcodes in `din[ADDR_SIZE+1:ADDR_SIZE]`:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data / trigger (payload 0)
- States: IDLE, W_ADDR, W_DATA, R_ADDR, R_CMD, WAIT, RESP.
- IDLE: on accept, go to W_ADDR if `req_write`, else R_ADDR. Latch addr, wdata and op.
- W_ADDR: `din`={00,addr}, `rx_valid`=1 → W_DATA.
- W_DATA: `din`={01,wdata}, `rx_valid`=1 → RESP.
- R_ADDR: `din`={10,addr}, `rx_valid`=1 → R_CMD.
- R_CMD: `din`={11,0}, `rx_valid`=1 → WAIT; clear timeout counter.
- WAIT: `rx_valid`=0.
  - Edge with `tx_valid`=1: capture `dout` into `rsp_rdata`, `rsp_err`=0 → RESP.
  - Otherwise counter+1. If the counter is already RD_TIMEOUT-1: `rsp_rdata`=0, `rsp_err`=1 → RESP.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- `tx_valid` in any state other than WAIT is ignored; it causes no capture and no error.
- Counter width is $clog2(RD_TIMEOUT+1). It never wraps because the exit happens first.
- Request inputs are don't-care except at the accept edge.

## Timing
- All outputs come from registers or decode of the state register.
- After the reset edge:
  - state=IDLE, `req_ready`=1
  - `rx_valid`=0, `din`=0
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
- Edges are counted from the accept edge E0.
- Write:
  - {00,addr} with `rx_valid` after E0; {01,wdata} after E1.
  - `rsp_valid` after E2.
  - `req_ready`=1 after E3.
- Read:
  - {10,addr} after E0; {11,0} after E1; WAIT after E2.
  - If the RAM answers with `tx_valid` visible in the cycle after E2 (sampled at E3), `rsp_valid` follows E3. Read latency is 3 edges plus RAM delay.
- Timeout: with no `tx_valid`, `rsp_valid`+`rsp_err` follow edge E2+RD_TIMEOUT (E17 at default).
- If `tx_valid` is high on the final timeout edge, success wins.
- Command words are back-to-back; `rx_valid` is high for exactly 2 consecutive cycles per request.
- Next accept is possible at the edge after the `rsp_valid` cycle. Minimum spacing between accepts is 4 edges for a write.
- Reset mid-operation:
  - Abort: IDLE after the reset edge, `rx_valid`=0.
  - No `rsp_valid` for the aborted request.
  - A partially sent sequence is not completed.

## Test plan
- Reset: hold `rst` for 2 cycles with `req_valid`=1 → all outputs at reset values, no accept; `req_ready`=1 after release.
- Write addr 8'h3C data 8'hA5 → `din`=10'h03C then 10'h1A5 with `rx_valid` high 2 cycles. One `rsp_valid` after E2 with `rsp_err`=0 and `rsp_rdata`=0.
- Read 8'h3C against the RAM model after the previous write → `din`=10'h23C then 10'h300. `rsp_valid` with `rsp_rdata`=8'hA5 and `rsp_err`=0.
- Read with `tx_valid` tied 0 → exactly one `rsp_valid` after E17 with `rsp_err`=1 and `rsp_rdata`=0. A `tx_valid` pulse injected at E17 instead yields `rsp_err`=0.
- `rst` asserted in R_CMD → `rx_valid`=0 the next cycle, no `rsp_valid`, `req_ready`=1. A following write 8'h01/8'h5A completes normally.
- Spurious `tx_valid` in IDLE/W_DATA ignored. Back-to-back writes with `req_valid` held high are accepted at E0 and E4.
